// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin share of one LC-3 ALU between two valid/ready requesters,
// with a one-entry registered result stage carrying requester tag and NZP.
module alu_arbiter (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [1:0]  req0_op,
    input  logic [15:0] req0_a,
    input  logic [15:0] req0_b,
    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [1:0]  req1_op,
    input  logic [15:0] req1_a,
    input  logic [15:0] req1_b,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic        resp_id,
    output logic [15:0] resp_data,
    output logic [2:0]  resp_nzp
);
    logic        last_grant;
    logic        free;
    logic        grant;
    logic        accept;
    logic [1:0]  alu_op;
    logic [15:0] alu_a;
    logic [15:0] alu_b;
    logic [15:0] alu_y;
    logic [2:0]  nzp;

    // Under contention the port that did not win last accept goes next.
    always_comb begin
        free       = !resp_valid | resp_ready;
        grant      = (req0_valid & req1_valid) ? !last_grant : req1_valid;
        req0_ready = req0_valid & free & !grant;
        req1_ready = req1_valid & free & grant;
        accept     = req0_ready | req1_ready;
        alu_op     = grant ? req1_op : req0_op;
        alu_a      = grant ? req1_a  : req0_a;
        alu_b      = grant ? req1_b  : req0_b;
        nzp        = {alu_y[15], alu_y == 16'h0000, !alu_y[15] & (|alu_y)};
    end

    arithmetic_logic_unit alu (
        .sel (alu_op),
        .a   (alu_a),
        .b   (alu_b),
        .y   (alu_y)
    );

    // Priority rotates only on an actual accept; a drain alone keeps the data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            resp_valid <= 1'b0;
            resp_id    <= 1'b0;
            resp_data  <= 16'h0000;
            resp_nzp   <= 3'b000;
            last_grant <= 1'b1;
        end else if (accept) begin
            resp_valid <= 1'b1;
            resp_id    <= grant;
            resp_data  <= alu_y;
            resp_nzp   <= nzp;
            last_grant <= grant;
        end else if (resp_ready) begin
            resp_valid <= 1'b0;
        end
    end
endmodule

// arithmetic_logic_unit: LC-3 ALU, select 00 ADD, 01 NOT a, 10 AND, 11 zero.
module arithmetic_logic_unit (
    input  logic [1:0]  sel,
    input  logic [15:0] a,
    input  logic [15:0] b,
    output logic [15:0] y
);
    always_comb
        y = (sel == 2'b00) ? a + b :
            (sel == 2'b01) ? ~a :
            (sel == 2'b10) ? a & b : 16'h0000;
endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Shares the single LC-3 ALU (`arithmetic_logic_unit`: select 00 ADD, 01 NOT in_a, 10 AND, 11 zero) between two requesters: the instruction execute path (port 0) and the address/increment path (port 1). Uses round-robin arbitration with valid/ready handshakes on both request ports. Results are held in a one-entry registered output stage with a requester tag and the LC-3 NZP condition code, so the stage sits between decode/execute and register-file writeback.

## Interface
Parameters: none (datapath fixed at 16 bits, 2 requesters).

- `clk`  in  1  single clock; all state changes on rising edge
- `rst_n`  in  1  asynchronous active-low reset
- `req0_valid`  in  1  port 0 has an operation
- `req0_ready`  out  1  port 0 operation accepted this cycle when high with valid
- `req0_op`  in  2  ALU select for port 0
- `req0_a`, `req0_b`  in  16 each  port 0 operands
- `req1_valid`, `req1_ready`, `req1_op`, `req1_a`, `req1_b`  as port 0, for port 1
- `resp_valid`  out  1  result register holds a result
- `resp_ready`  in  1  consumer takes result this cycle when high with valid
- `resp_id`  out  1  requester that issued the held result
- `resp_data`  out  16  ALU result
- `resp_nzp`  out  3  {N,Z,P} of `resp_data`

## Operation
- Internal ALU instance is fed from the granted port's op/a/b through a 2:1 operand mux.
- Stage free condition: `free = !resp_valid | resp_ready`.
- Grant (combinational):
  - only one port valid → that port;
  - both valid → port != `last_grant`;
  - neither valid → no grant.
- `reqN_ready = grant==N & reqN_valid & free`. Never both high. Ready may depend combinationally on both valids and `resp_ready`; requesters must not make valid depend on ready.
- On accept (`reqN_valid & reqN_ready`), load `resp_data` = ALU out, `resp_id` = N, `resp_nzp`, set `resp_valid`, and set `last_grant` = N.
- `last_grant` updates only on accept. An idle cycle or a stalled grant does not rotate priority.
- Without a new accept, a `resp_valid & resp_ready` handshake clears `resp_valid`. `resp_data`/`resp_id`/`resp_nzp` then hold their last values.
- Accept with simultaneous drain: the register is overwritten with the new result and `resp_valid` stays 1, giving full throughput.
- NZP rules:
  - N = data[15];
  - Z = (data == 0);
  - P = !N & !Z;
  - exactly one bit is set whenever `resp_valid` is high.
- Arithmetic: ADD is modulo 2^16 with carry discarded and no overflow flag. Op 11 returns 0x0000 with nzp 010.
- While `resp_valid & !resp_ready` (stall), the held outputs are stable and both readies are 0.
- Two-state view:
  - EMPTY (`resp_valid` = 0): accepts any grant.
  - FULL (`resp_valid` = 1): accepts only when `resp_ready` is high. Goes to EMPTY on drain without accept.

## Timing
- Reset (async assert, sync release by the system) sets `resp_valid` = 0, `resp_data` = 0x0000, `resp_id` = 0, `resp_nzp` = 000, `last_grant` = 1 (port 0 wins the first contention). A held result is discarded.
- Latency: an op accepted at edge k appears on `resp_*` after edge k; `resp_valid` is high in cycle k+1.
- Throughput: one op per cycle while `resp_ready` is held high.
- Outputs `resp_*` come directly from flops. `reqN_ready` is combinational.
- Operands and op are sampled only at the accepting edge; later changes do not affect the held result.

## Test plan
- Reset then single op: port 0 issues ADD a=0x0005 b=0xFFFB with `resp_ready`=1 → `req0_ready`=1. Next cycle: `resp_valid`=1, data=0x0000, nzp=010, id=0.
- Contention: both ports valid every cycle, port 0 ADD 0x7FFF+0x0001, port 1 NOT a=0x00FF, `resp_ready`=1 → grants alternate 0,1,0,1 starting with 0; data 0x8000 (nzp 100), 0xFF00 (nzp 100).
- Backpressure: FULL with `resp_ready`=0 for 3 cycles while port 1 is valid → both readies 0, outputs stable. `resp_ready` rises → port 1 is accepted in the same cycle and the register is replaced without a bubble.
- Priority not rotated by idle: port 1 accepted, then 2 idle cycles, then both valid → port 0 granted.
- Op 11 and AND: port 1 op 11 a=0x1234 → data 0x0000, nzp 010. Then AND 0x0F0F & 0x00FF → 0x000F, nzp 001.
- Async reset while FULL and unstalled: `rst_n` low mid-cycle → `resp_valid` drops immediately, data 0. After release, both valid → port 0 granted first.
